// File: rtl/baud_pkg.sv
// Shared definitions for the autobaud detector and the baud rate generator.
package baud_pkg;

  // Detector state encoding
  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    MEASURE,
    DONE
  } state_t;

  // Generator divisor values (cycles-per-bit minus 1) for a 50 MHz clock
  localparam logic [15:0] BAUD_9600   = 16'd5207;
  localparam logic [15:0] BAUD_38400  = 16'd1301;
  localparam logic [15:0] BAUD_57600  = 16'd867;
  localparam logic [15:0] BAUD_115200 = 16'd433;

  // Sync character and the number of bit intervals it spans (first fall to last fall)
  localparam logic [7:0] SYNC_CHAR      = 8'h55;
  localparam int         SYNC_INTERVALS = 8;

endpackage

// File: rtl/rx_sync_edge.sv
// Brings an asynchronous serial line into the clk domain and flags its edges.
// Shared with the UART receiver, so it has no knowledge of bit timing.
module rx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q,  dly_d;

  // Shift chain: two synchronizer stages, then one delay stage for edge compare
  always_comb begin
    meta_d = rx;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  // Flops reset to the idle-high line level so reset release never looks like a start bit
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      dly_q  <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign rx_s = sync_q;
  assign rise = ~dly_q &  sync_q;
  assign fall =  dly_q & ~sync_q;

endmodule

// File: rtl/baud_detector.sv
// Autobaud detector: times the nine edges of a 0x55 sync character and reports
// the average bit period as cycles-per-bit minus 1 (the generator's divisor).
module baud_detector
  import baud_pkg::*;
#(
  parameter logic [15:0] BAUD_DEFAULT = BAUD_9600,
  parameter int          MIN_BIT      = 16,
  parameter int          MAX_BIT      = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx,
  output logic [15:0] baud_value,
  output logic        baud_valid,
  output logic        lock,
  output logic        error,
  output logic        busy
);

  localparam logic [16:0] MIN_IVL   = 17'(MIN_BIT);
  localparam logic [16:0] MAX_IVL   = 17'(MAX_BIT);
  localparam logic [3:0]  LAST_IVL  = 4'(SYNC_INTERVALS - 1);
  localparam logic [17:0] MAX_AVG   = 18'd65536;

  // Rounded average over the eight sync intervals: (total + 4) / 8
  function automatic logic [17:0] round_avg(input logic [19:0] total);
    logic [20:0] sum;
    sum = {1'b0, total} + 21'd4;
    return sum[20:3];
  endfunction

  // Magnitude of the difference between two interval lengths
  function automatic logic [16:0] abs_diff(input logic [16:0] a, input logic [16:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic rx_s, rise, fall;

  rx_sync_edge u_sync (
    .clk  (clk),
    .reset(reset),
    .rx   (rx),
    .rx_s (rx_s),
    .rise (rise),
    .fall (fall)
  );

  state_t      state_q, state_d;
  logic [16:0] ivl_q,   ivl_d;
  logic [19:0] tot_q,   tot_d;
  logic [16:0] t0_q,    t0_d;
  logic [3:0]  ecnt_q,  ecnt_d;
  logic [15:0] baud_q,  baud_d;
  logic        valid_q, valid_d;
  logic        lock_q,  lock_d;
  logic        error_q, error_d;

  logic [17:0] avg;
  logic [17:0] ivl_limit;
  logic        ivl_far;

  // Tolerance window around the first interval: t0 +/- t0/4
  always_comb begin
    avg       = round_avg(tot_q);
    ivl_limit = {1'b0, t0_q} + {3'b000, t0_q[16:2]};
    ivl_far   = abs_diff(ivl_q, t0_q) > {2'b00, t0_q[16:2]};
  end

  // Next-state logic: measurement sequencing, interval checks and result update
  always_comb begin
    state_d = state_q;
    ivl_d   = ivl_q;
    tot_d   = tot_q;
    t0_d    = t0_q;
    ecnt_d  = ecnt_q;
    baud_d  = baud_q;
    valid_d = valid_q;
    lock_d  = 1'b0;
    error_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // Re-arm only on an idle-high line so a rejected character's tail is not a start bit
          if (rx_s) state_d = WAIT_START;
        end
        WAIT_START: begin
          if (fall) begin
            ivl_d   = 17'd1;
            tot_d   = 20'd1;
            ecnt_d  = 4'd0;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          ivl_d = ivl_q + 17'd1;
          tot_d = tot_q + 20'd1;
          if (rise | fall) begin
            if (ivl_q < MIN_IVL) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else if (ecnt_q == 4'd0) begin
              t0_d   = ivl_q;
              ecnt_d = 4'd1;
              ivl_d  = 17'd1;
            end else if (ivl_far) begin
              error_d = 1'b1;
              state_d = IDLE;
            end else begin
              ecnt_d = ecnt_q + 4'd1;
              ivl_d  = 17'd1;
              if (ecnt_q == LAST_IVL && fall) begin
                // Freeze the total at exactly eight bit times
                tot_d   = tot_q;
                state_d = DONE;
              end
            end
          end else if (ecnt_q == 4'd0) begin
            if (ivl_q == MAX_IVL) begin
              error_d = 1'b1;
              state_d = IDLE;
            end
          end else if ({1'b0, ivl_q} > ivl_limit) begin
            error_d = 1'b1;
            state_d = IDLE;
          end
        end
        DONE: begin
          state_d = IDLE;
          if (avg > MAX_AVG) begin
            error_d = 1'b1;
          end else begin
            baud_d  = avg[15:0] - 16'd1;
            valid_d = 1'b1;
            lock_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs; reset restores the default divisor
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ivl_q   <= '0;
      tot_q   <= '0;
      t0_q    <= '0;
      ecnt_q  <= '0;
      baud_q  <= BAUD_DEFAULT;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ivl_q   <= ivl_d;
      tot_q   <= tot_d;
      t0_q    <= t0_d;
      ecnt_q  <= ecnt_d;
      baud_q  <= baud_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      error_q <= error_d;
    end
  end

  assign baud_value = baud_q;
  assign baud_valid = valid_q;
  assign lock       = lock_q;
  assign error      = error_q;
  assign busy       = (state_q == MEASURE);

endmodule

// File: tb/tb_baud_detector.sv
// Bench for baud_detector: drives 8N1 characters with optional edge jitter and
// compares the outcome against an edge-timing reference model.
module tb_baud_detector;
  import baud_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] baud_value;
  logic        baud_valid;
  logic        lock;
  logic        error;
  logic        busy;

  baud_detector dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rx        (rx),
    .baud_value(baud_value),
    .baud_valid(baud_valid),
    .lock      (lock),
    .error     (error),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int lock_cnt = 0;
  int err_cnt = 0;
  int overlap_cnt = 0;
  int last_lock_cyc = 0;

  // Bench-side expectation of the detector's held result
  int exp_baud = 5207;
  int exp_valid = 0;

  // Edge times (in clocks) of the character currently being sent
  int model_et[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor
  always @(negedge clk) begin
    if (lock) begin
      lock_cnt <= lock_cnt + 1;
      last_lock_cyc <= cyc;
    end
    if (error) err_cnt <= err_cnt + 1;
    if (lock && error) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic hold(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: a sync character is accepted when at least nine edges arrive, every
  // interval is >= 16 clocks, intervals 2..8 are within t0/4 of the first, and the
  // rounded mean of the eight intervals fits the 16-bit divisor.
  function automatic void model_char(output bit ok, output int val);
    int t0, iv, d, tot, avg;
    ok = 1'b0;
    val = 0;
    if (model_et.size() < 9) return;
    t0 = model_et[1] - model_et[0];
    if (t0 < 16 || t0 > 65536) return;
    for (int i = 2; i <= 8; i++) begin
      iv = model_et[i] - model_et[i-1];
      d = (iv > t0) ? iv - t0 : t0 - iv;
      if (iv < 16 || d > t0 / 4) return;
    end
    tot = model_et[8] - model_et[0];
    avg = (tot + 4) / 8;
    if (avg > 65536) return;
    ok = 1'b1;
    val = avg - 1;
  endfunction

  // Send one 8N1 character at p clocks/bit; interior bit boundaries 1..7 get +/-jit jitter
  task automatic run_char(input string name, input logic [7:0] data, input int p,
                          input int jit, input int tail);
    int b[11];
    logic [9:0] lv;
    logic prev;
    int edge_k[$];
    int l0, e0, fall_cyc, exp_val;
    bit ok;
    lv = {1'b1, data, 1'b0};
    b[0] = 0;
    for (int k = 1; k < 10; k++) begin
      b[k] = k * p;
      if (k <= 7 && jit > 0) b[k] += int'($urandom_range(2 * jit)) - jit;
    end
    b[10] = 10 * p;
    model_et.delete();
    prev = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (lv[k] !== prev) begin
        model_et.push_back(b[k]);
        edge_k.push_back(k);
      end
      prev = lv[k];
    end
    model_char(ok, exp_val);
    l0 = lock_cnt;
    e0 = err_cnt;
    fall_cyc = 0;
    for (int k = 0; k < 10; k++) begin
      rx = lv[k];
      if (edge_k.size() >= 9 && k == edge_k[8]) fall_cyc = cyc;
      repeat (b[k+1] - b[k]) @(posedge clk);
      #1;
    end
    hold(1'b1, tail);
    if (ok) begin
      exp_baud = exp_val;
      exp_valid = 1;
      check_eq({name, "_lock"}, lock_cnt - l0, 1);
      check_eq({name, "_err"}, err_cnt - e0, 0);
      check_eq({name, "_latency"}, last_lock_cyc - fall_cyc, 4);
    end else begin
      check_eq({name, "_lock"}, lock_cnt - l0, 0);
      check_eq({name, "_err"}, (err_cnt - e0) > 0, 1);
    end
    check_eq({name, "_baud"}, baud_value, exp_baud);
    check_eq({name, "_valid"}, baud_valid, exp_valid);
  endtask

  initial begin
    int l0, e0, p;
    // Reset state
    reset = 1'b0;
    enable = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_baud", baud_value, 5207);
    check_eq("rst_valid", baud_valid, 0);
    check_eq("rst_lock", lock, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b1;
    hold(1'b1, 20);

    // 115200 with +/-2 clock jitter on interior edges
    run_char("c434_jit", SYNC_CHAR, 434, 2, 20);

    // Reset mid-measurement after the 433 lock
    l0 = lock_cnt;
    e0 = err_cnt;
    hold(1'b0, 434);
    hold(1'b1, 434);
    hold(1'b0, 100);
    check_eq("midrst_busy_before", busy, 1);
    reset = 1'b0;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_baud = 5207;
    exp_valid = 0;
    check_eq("midrst_baud", baud_value, exp_baud);
    check_eq("midrst_valid", baud_valid, exp_valid);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_lock", lock_cnt - l0, 0);
    hold(1'b1, 20);

    // 9600 baud
    run_char("c5208", SYNC_CHAR, 5208, 0, 20);

    // Short low glitch on an idle line
    l0 = lock_cnt;
    e0 = err_cnt;
    hold(1'b0, 8);
    hold(1'b1, 40);
    check_eq("glitch_err", err_cnt - e0, 1);
    check_eq("glitch_lock", lock_cnt - l0, 0);
    check_eq("glitch_baud", baud_value, exp_baud);

    // Clean 38400 character after the glitch
    run_char("c1302", SYNC_CHAR, 1302, 0, 20);

    // Wrong character: long low stretch trips the interval timeout
    run_char("c41", 8'h41, 868, 0, 908);

    // Enable dropped after the fourth edge
    p = 1302;
    l0 = lock_cnt;
    e0 = err_cnt;
    hold(1'b0, p);
    hold(1'b1, p);
    hold(1'b0, p);
    hold(1'b1, 10);
    check_eq("endrop_busy_before", busy, 1);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_eq("endrop_busy_after", busy, 0);
    hold(1'b1, 200);
    check_eq("endrop_lock", lock_cnt - l0, 0);
    check_eq("endrop_err", err_cnt - e0, 0);
    check_eq("endrop_baud", baud_value, exp_baud);
    enable = 1'b1;
    hold(1'b1, 20);

    // Randomized rates and jitter; the model decides lock or reject
    for (int n = 0; n < 6; n++) begin
      p = int'($urandom_range(60, 24));
      run_char($sformatf("rnd%0d", n), SYNC_CHAR, p, p / 6 + 1, p + 40);
    end

    check_eq("lock_err_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
